// File: rtl/core_sequencer_pkg.sv
// Shared types and constants for the RV32I multi-cycle sequencer.
// Holds the FSM state encoding, trap causes and the decoder/opcode constants.
package core_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_TRAP      = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'b00,
        CAUSE_ILLEGAL = 2'b01,
        CAUSE_TIMEOUT = 2'b10
    } trap_cause_t;

    localparam logic [3:0]  ALU_INVALID = 4'hF;
    localparam logic [6:0]  OPC_RTYPE   = 7'b0110011;
    localparam logic [6:0]  OPC_ITYPE   = 7'b0010011;
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

    // Writes to x0 are architecturally discarded, so no write strobe is issued.
    function automatic logic rd_nonzero(input logic [31:0] instr);
        return instr[11:7] != 5'd0;
    endfunction

endpackage

// File: rtl/core_sequencer_if.sv
// Instruction-memory fetch bus between the sequencer (master) and imem (slave).
// Handshake: imem_req rises with imem_addr and both hold stable until the slave
// returns a single-cycle imem_ack carrying imem_rdata; ack without req is ignored.
interface core_sequencer_if #(
    parameter int XLEN = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [31:0]     imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/core_sequencer_imem_fetch_if.sv
// Fetch handshake engine: drives req/addr while the FSM is fetching, reports
// completion on ack, and flags a timeout after IMEM_TIMEOUT unacknowledged cycles.
module imem_fetch_if #(
    parameter int XLEN         = 32,
    parameter int IMEM_TIMEOUT = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    fetch,
    input  logic [XLEN-1:0]         addr,
    core_sequencer_if.master        imem,
    output logic                    done,
    output logic                    timeout,
    output logic [31:0]             rdata
);

    localparam logic [7:0] WAIT_LIMIT = 8'(IMEM_TIMEOUT - 1);

    logic [7:0] wait_cnt;

    // Request is a pure function of the FSM state so an async reset drops it at once.
    assign imem.imem_req  = fetch;
    assign imem.imem_addr = addr;
    assign rdata          = imem.imem_rdata;

    assign done    = fetch && imem.imem_ack;
    assign timeout = fetch && !imem.imem_ack && (wait_cnt == WAIT_LIMIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (!fetch || imem.imem_ack) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle RV32I instruction sequencer: FETCH -> DECODE -> EXECUTE -> WRITEBACK,
// with a sticky TRAP state for illegal instructions and fetch timeouts.
module core_sequencer
    import core_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_PC     = '0,
    parameter int              IMEM_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    core_sequencer_if.master  imem,
    output logic [31:0]       ir,
    input  logic [3:0]        dec_alu_control,
    input  logic              dec_regwrite,
    input  logic              dec_imm,
    output logic [3:0]        alu_op,
    output logic              alu_src_imm,
    output logic              rf_re,
    output logic              alu_en,
    output logic              rf_we,
    output logic [XLEN-1:0]   pc,
    output logic [31:0]       retired,
    output logic              trap,
    output logic [1:0]        trap_cause,
    output state_t            state_dbg
);

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q;
    logic [31:0]     ir_q;
    logic [3:0]      alu_op_q;
    logic            alu_src_imm_q;
    logic [31:0]     retired_q;
    trap_cause_t     cause_q;

    logic            fetch_active;
    logic            fetch_done;
    logic            fetch_timeout;
    logic [31:0]     fetch_rdata;
    logic            decode_illegal;

    imem_fetch_if #(
        .XLEN         (XLEN),
        .IMEM_TIMEOUT (IMEM_TIMEOUT)
    ) u_fetch (
        .clk     (clk),
        .rst     (rst),
        .fetch   (fetch_active),
        .addr    (pc_q),
        .imem    (imem),
        .done    (fetch_done),
        .timeout (fetch_timeout),
        .rdata   (fetch_rdata)
    );

    // Only ALU-producing, register-writing instructions are supported.
    assign decode_illegal = (dec_alu_control == ALU_INVALID) || !dec_regwrite;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (run) state_d = ST_FETCH;
            ST_FETCH: begin
                if (fetch_done) begin
                    state_d = ST_DECODE;
                end else if (fetch_timeout) begin
                    state_d = ST_TRAP;
                end
            end
            ST_DECODE:    state_d = decode_illegal ? ST_TRAP : ST_EXECUTE;
            ST_EXECUTE:   state_d = ST_WRITEBACK;
            ST_WRITEBACK: state_d = run ? ST_FETCH : ST_IDLE;
            ST_TRAP:      state_d = ST_TRAP;
            default:      state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        fetch_active = 1'b0;
        rf_re        = 1'b0;
        alu_en       = 1'b0;
        rf_we        = 1'b0;
        trap         = 1'b0;
        case (state_q)
            ST_FETCH:     fetch_active = 1'b1;
            ST_DECODE:    rf_re        = 1'b1;
            ST_EXECUTE:   alu_en       = 1'b1;
            ST_WRITEBACK: rf_we        = rd_nonzero(ir_q);
            ST_TRAP:      trap         = 1'b1;
            default:      ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            ir_q          <= NOP_INSTR;
            alu_op_q      <= ALU_INVALID;
            alu_src_imm_q <= 1'b0;
            retired_q     <= '0;
            cause_q       <= CAUSE_NONE;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (fetch_done) begin
                        ir_q <= fetch_rdata;
                    end else if (fetch_timeout) begin
                        cause_q <= CAUSE_TIMEOUT;
                    end
                end
                ST_DECODE: begin
                    if (decode_illegal) begin
                        cause_q <= CAUSE_ILLEGAL;
                    end else begin
                        alu_op_q      <= dec_alu_control;
                        alu_src_imm_q <= dec_imm;
                    end
                end
                ST_WRITEBACK: begin
                    pc_q      <= pc_q + XLEN'(4);
                    retired_q <= retired_q + 32'd1;
                end
                default: ;
            endcase
        end
    end

    assign pc          = pc_q;
    assign ir          = ir_q;
    assign alu_op      = alu_op_q;
    assign alu_src_imm = alu_src_imm_q;
    assign retired     = retired_q;
    assign trap_cause  = cause_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Scenario bench for core_sequencer: an instruction-memory responder, a reference
// RV32I ALU decoder and per-scenario tasks checked against a PC/retire model.
module tb_core_sequencer;
    import core_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0;
    localparam int          TIMEOUT  = 8;
    localparam int          B2B_N    = 24;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic [31:0] ir;
    logic [3:0]  dec_alu_control;
    logic        dec_regwrite;
    logic        dec_imm;
    logic [3:0]  alu_op;
    logic        alu_src_imm;
    logic        rf_re;
    logic        alu_en;
    logic        rf_we;
    logic [31:0] pc;
    logic [31:0] retired;
    logic        trap;
    logic [1:0]  trap_cause;
    state_t      state_dbg;

    core_sequencer_if #(.XLEN(32)) imem_bus ();

    core_sequencer #(
        .XLEN         (32),
        .RESET_PC     (RESET_PC),
        .IMEM_TIMEOUT (TIMEOUT)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .run             (run),
        .imem            (imem_bus),
        .ir              (ir),
        .dec_alu_control (dec_alu_control),
        .dec_regwrite    (dec_regwrite),
        .dec_imm         (dec_imm),
        .alu_op          (alu_op),
        .alu_src_imm     (alu_src_imm),
        .rf_re           (rf_re),
        .alu_en          (alu_en),
        .rf_we           (rf_we),
        .pc              (pc),
        .retired         (retired),
        .trap            (trap),
        .trap_cause      (trap_cause),
        .state_dbg       (state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_pc      = RESET_PC;
    logic [31:0] exp_retired = 32'd0;

    // ---------------- reference decoder: {alu[3:0], regwrite, imm} ----------------
    function automatic logic [5:0] ref_decode(input logic [31:0] i);
        logic [3:0] alu = ALU_INVALID;
        logic [3:0] base = ALU_INVALID;
        case (i[14:12])
            3'b000:  base = 4'b0010;
            3'b111:  base = 4'b0000;
            3'b110:  base = 4'b0001;
            3'b010:  base = 4'b0111;
            default: base = ALU_INVALID;
        endcase
        if (i[6:0] == OPC_ITYPE) alu = base;
        else if (i[6:0] == OPC_RTYPE && i[31:25] == 7'h00) alu = base;
        else if (i[6:0] == OPC_RTYPE && i[31:25] == 7'h20 && i[14:12] == 3'b000) alu = 4'b0110;
        return {alu, (i[6:0] == OPC_ITYPE) || (i[6:0] == OPC_RTYPE), i[6:0] == OPC_ITYPE};
    endfunction

    assign {dec_alu_control, dec_regwrite, dec_imm} = ref_decode(ir);

    function automatic logic [31:0] gen_legal();
        logic [4:0]  rd  = 5'($urandom_range(0, 31));
        logic [4:0]  rs1 = 5'($urandom_range(0, 31));
        logic [4:0]  rs2 = 5'($urandom_range(0, 31));
        logic [11:0] imm = 12'($urandom);
        logic [2:0]  f3;
        case ($urandom_range(0, 3))
            0:       f3 = 3'b000;
            1:       f3 = 3'b111;
            2:       f3 = 3'b110;
            default: f3 = 3'b010;
        endcase
        case ($urandom_range(0, 2))
            0:       return {imm, rs1, f3, rd, OPC_ITYPE};
            1:       return {7'h00, rs2, rs1, f3, rd, OPC_RTYPE};
            default: return {7'h20, rs2, rs1, 3'b000, rd, OPC_RTYPE};
        endcase
    endfunction

    // ---------------- instruction-memory responder ----------------
    int          ack_delay  = 0;
    bit          ack_enable = 1'b1;
    bit          late_ack   = 1'b0;
    int          ack_wait   = 0;
    logic [31:0] mem [logic [31:0]];

    always @(negedge clk) begin
        imem_bus.imem_ack = 1'b0;
        if (late_ack) begin
            imem_bus.imem_ack   = 1'b1;
            imem_bus.imem_rdata = 32'hDEAD_BEEF;
        end else if (!rst && ack_enable && imem_bus.imem_req) begin
            if (ack_wait >= ack_delay) begin
                imem_bus.imem_ack   = 1'b1;
                imem_bus.imem_rdata = mem.exists(imem_bus.imem_addr) ? mem[imem_bus.imem_addr] : NOP_INSTR;
                ack_wait = 0;
            end else begin
                ack_wait++;
            end
        end else begin
            ack_wait = 0;
        end
    end

    task automatic do_reset();
        rst = 1'b1; run = 1'b0; ack_enable = 1'b1; late_ack = 1'b0; ack_delay = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_pc = RESET_PC; exp_retired = 32'd0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; run = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (pc !== RESET_PC) begin n_fail++; $display("FAIL reset_pc: got %h expected %h", pc, RESET_PC); end
        n_checks++; if (ir !== NOP_INSTR) begin n_fail++; $display("FAIL reset_ir: got %h expected %h", ir, NOP_INSTR); end
        n_checks++; if (alu_op !== 4'hF) begin n_fail++; $display("FAIL reset_alu_op: got %h expected f", alu_op); end
        n_checks++; if (alu_src_imm !== 1'b0) begin n_fail++; $display("FAIL reset_alu_src_imm: got %b expected 0", alu_src_imm); end
        n_checks++; if (retired !== 32'd0) begin n_fail++; $display("FAIL reset_retired: got %0d expected 0", retired); end
        n_checks++; if (trap !== 1'b0 || trap_cause !== 2'b00) begin n_fail++; $display("FAIL reset_trap: got %b/%b expected 0/00", trap, trap_cause); end
        n_checks++; if ({imem_bus.imem_req, rf_re, alu_en, rf_we} !== 4'b0) begin n_fail++; $display("FAIL reset_strobes: got %b expected 0000", {imem_bus.imem_req, rf_re, alu_en, rf_we}); end
        n_checks++; if (state_dbg !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected %0d", state_dbg, ST_IDLE); end
        run = 1'b0; rst = 1'b0;
        exp_pc = RESET_PC; exp_retired = 32'd0;
    endtask

    task automatic test_addi_zero_wait();
        mem[32'h0] = 32'h0050_0093;
        ack_delay = 0; run = 1'b1;
        @(negedge clk);
        n_checks++; if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h0) begin n_fail++; $display("FAIL addi_fetch: req=%b addr=%h expected 1/00000000", imem_bus.imem_req, imem_bus.imem_addr); end
        @(negedge clk);
        n_checks++; if ({rf_re, alu_en, rf_we} !== 3'b100) begin n_fail++; $display("FAIL addi_cycle2: strobes=%b expected 100", {rf_re, alu_en, rf_we}); end
        n_checks++; if (ir !== 32'h0050_0093) begin n_fail++; $display("FAIL addi_ir: got %h expected 00500093", ir); end
        @(negedge clk);
        n_checks++; if ({rf_re, alu_en, rf_we} !== 3'b010) begin n_fail++; $display("FAIL addi_cycle3: strobes=%b expected 010", {rf_re, alu_en, rf_we}); end
        n_checks++; if (alu_op !== 4'b0010 || alu_src_imm !== 1'b1) begin n_fail++; $display("FAIL addi_alu: op=%b imm=%b expected 0010/1", alu_op, alu_src_imm); end
        @(negedge clk);
        n_checks++; if ({rf_re, alu_en, rf_we} !== 3'b001) begin n_fail++; $display("FAIL addi_cycle4: strobes=%b expected 001", {rf_re, alu_en, rf_we}); end
        run = 1'b0;
        @(negedge clk);
        exp_pc = 32'd4; exp_retired = 32'd1;
        n_checks++; if (pc !== exp_pc || retired !== exp_retired) begin n_fail++; $display("FAIL addi_retire: pc=%h retired=%0d expected %h/%0d", pc, retired, exp_pc, exp_retired); end
        n_checks++; if (imem_bus.imem_req !== 1'b0 || state_dbg !== ST_IDLE) begin n_fail++; $display("FAIL addi_idle: req=%b state=%0d expected 0/%0d", imem_bus.imem_req, state_dbg, ST_IDLE); end
    endtask

    task automatic test_delayed_ack();
        int req_cycles = 0;
        mem[32'h4] = 32'h0070_0113;
        ack_delay = 3; run = 1'b1;
        @(negedge clk);
        while (imem_bus.imem_req === 1'b1 && req_cycles < 10) begin
            req_cycles++;
            n_checks++; if (imem_bus.imem_addr !== exp_pc) begin n_fail++; $display("FAIL delay_addr: got %h expected %h", imem_bus.imem_addr, exp_pc); end
            n_checks++; if (ir !== 32'h0050_0093) begin n_fail++; $display("FAIL delay_ir_hold: got %h expected 00500093", ir); end
            @(negedge clk);
        end
        n_checks++; if (req_cycles != 4) begin n_fail++; $display("FAIL delay_req_cycles: got %0d expected 4", req_cycles); end
        n_checks++; if (rf_re !== 1'b1 || ir !== 32'h0070_0113) begin n_fail++; $display("FAIL delay_decode: rf_re=%b ir=%h expected 1/00700113", rf_re, ir); end
        run = 1'b0; ack_delay = 0;
        repeat (3) @(negedge clk);
        exp_pc += 32'd4; exp_retired++;
        n_checks++; if (pc !== exp_pc || retired !== exp_retired) begin n_fail++; $display("FAIL delay_retire: pc=%h retired=%0d expected %h/%0d", pc, retired, exp_pc, exp_retired); end
    endtask

    task automatic test_rd_zero();
        int we_seen = 0, ex_seen = 0;
        mem[exp_pc] = 32'h0020_8033;
        ack_delay = 0; run = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (rf_re === 1'b1) run = 1'b0;
            if (rf_we !== 1'b0) we_seen++;
            if (alu_en === 1'b1) ex_seen++;
        end
        exp_pc += 32'd4; exp_retired++;
        n_checks++; if (we_seen != 0) begin n_fail++; $display("FAIL rd0_rf_we: high %0d cycles expected 0", we_seen); end
        n_checks++; if (ex_seen != 1) begin n_fail++; $display("FAIL rd0_alu_en: high %0d cycles expected 1", ex_seen); end
        n_checks++; if (pc !== exp_pc || retired !== exp_retired) begin n_fail++; $display("FAIL rd0_retire: pc=%h retired=%0d expected %h/%0d", pc, retired, exp_pc, exp_retired); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] instr_a [B2B_N];
        int          delay_a [B2B_N+1];
        logic [5:0]  d;
        int          last_re = 0;
        int          waited;
        for (int i = 0; i < B2B_N; i++) begin
            instr_a[i] = gen_legal();
            delay_a[i] = (i < 4) ? 0 : int'($urandom_range(0, 3));
            mem[exp_pc + 32'(4 * i)] = instr_a[i];
        end
        delay_a[B2B_N] = 0;
        ack_delay = delay_a[0]; run = 1'b1;
        for (int i = 0; i < B2B_N; i++) begin
            waited = 0;
            while (rf_re !== 1'b1 && waited < 20) begin @(negedge clk); waited++; end
            n_checks++; if (rf_re !== 1'b1) begin n_fail++; $display("FAIL b2b_decode_timeout: instr %0d rf_re=%b expected 1 within 20 cycles", i, rf_re); run = 1'b0; return; end
            ack_delay = delay_a[i+1];
            if (i == B2B_N - 1) run = 1'b0;
            n_checks++; if (ir !== instr_a[i]) begin n_fail++; $display("FAIL b2b_ir: instr %0d got %h expected %h", i, ir, instr_a[i]); end
            if (i > 0) begin
                n_checks++; if (cyc - last_re != 4 + delay_a[i]) begin n_fail++; $display("FAIL b2b_spacing: instr %0d got %0d cycles expected %0d", i, cyc - last_re, 4 + delay_a[i]); end
            end
            last_re = cyc;
            d = ref_decode(instr_a[i]);
            @(negedge clk);
            n_checks++; if (alu_en !== 1'b1 || alu_op !== d[5:2] || alu_src_imm !== d[0]) begin n_fail++; $display("FAIL b2b_execute: instr %0d en=%b op=%h imm=%b expected 1/%h/%b", i, alu_en, alu_op, alu_src_imm, d[5:2], d[0]); end
            @(negedge clk);
            n_checks++; if (rf_we !== (instr_a[i][11:7] != 5'd0) || pc !== exp_pc) begin n_fail++; $display("FAIL b2b_writeback: instr %0d rf_we=%b pc=%h expected %b/%h", i, rf_we, pc, instr_a[i][11:7] != 5'd0, exp_pc); end
            exp_pc += 32'd4; exp_retired++;
            @(negedge clk);
            n_checks++; if (pc !== exp_pc || retired !== exp_retired) begin n_fail++; $display("FAIL b2b_retire: instr %0d pc=%h retired=%0d expected %h/%0d", i, pc, retired, exp_pc, exp_retired); end
        end
    endtask

    task automatic test_drop_run();
        logic [31:0] instr = gen_legal();
        int          waited = 0, req_seen = 0;
        mem[exp_pc] = instr;
        ack_delay = int'($urandom_range(0, 2)); run = 1'b1;
        while (rf_re !== 1'b1 && waited < 20) begin @(negedge clk); waited++; end
        @(negedge clk);
        n_checks++; if (alu_en !== 1'b1) begin n_fail++; $display("FAIL drop_execute: alu_en=%b expected 1", alu_en); end
        run = 1'b0;
        @(negedge clk);
        n_checks++; if (rf_we !== (instr[11:7] != 5'd0)) begin n_fail++; $display("FAIL drop_writeback: rf_we=%b expected %b", rf_we, instr[11:7] != 5'd0); end
        exp_pc += 32'd4; exp_retired++;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (imem_bus.imem_req !== 1'b0) req_seen++;
        end
        n_checks++; if (req_seen != 0) begin n_fail++; $display("FAIL drop_no_fetch: req high %0d cycles expected 0", req_seen); end
        n_checks++; if (pc !== exp_pc || retired !== exp_retired || state_dbg !== ST_IDLE) begin n_fail++; $display("FAIL drop_idle: pc=%h retired=%0d state=%0d expected %h/%0d/%0d", pc, retired, state_dbg, exp_pc, exp_retired, ST_IDLE); end
    endtask

    task automatic test_async_reset();
        int ir_bad = 0;
        ack_enable = 1'b0; run = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (imem_bus.imem_req !== 1'b1 || pc === RESET_PC) begin n_fail++; $display("FAIL areset_pre: req=%b pc=%h expected 1/nonzero", imem_bus.imem_req, pc); end
        #2 rst = 1'b1;
        #1;
        n_checks++; if (imem_bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL areset_req: got %b expected 0 before clock edge", imem_bus.imem_req); end
        n_checks++; if (pc !== RESET_PC || retired !== 32'd0 || ir !== NOP_INSTR) begin n_fail++; $display("FAIL areset_regs: pc=%h retired=%0d ir=%h expected %h/0/%h", pc, retired, ir, RESET_PC, NOP_INSTR); end
        @(negedge clk);
        rst = 1'b0; run = 1'b0; ack_enable = 1'b1; late_ack = 1'b1;
        exp_pc = RESET_PC; exp_retired = 32'd0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (ir !== NOP_INSTR || state_dbg !== ST_IDLE) ir_bad++;
        end
        late_ack = 1'b0;
        n_checks++; if (ir_bad != 0) begin n_fail++; $display("FAIL areset_late_ack: ir/state disturbed %0d cycles expected 0", ir_bad); end
    endtask

    task automatic test_illegal();
        int waited = 0, bad = 0;
        mem[exp_pc] = 32'h4000_A0B3;
        ack_delay = 0; run = 1'b1;
        while (rf_re !== 1'b1 && waited < 20) begin @(negedge clk); waited++; end
        n_checks++; if (ir !== 32'h4000_A0B3) begin n_fail++; $display("FAIL illegal_ir: got %h expected 4000a0b3", ir); end
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (alu_en !== 1'b0 || rf_we !== 1'b0 || rf_re !== 1'b0 || imem_bus.imem_req !== 1'b0) bad++;
        end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL illegal_quiet: strobes/req high %0d cycles expected 0", bad); end
        n_checks++; if (trap !== 1'b1 || trap_cause !== 2'b01) begin n_fail++; $display("FAIL illegal_trap: trap=%b cause=%b expected 1/01", trap, trap_cause); end
        n_checks++; if (pc !== exp_pc || retired !== exp_retired) begin n_fail++; $display("FAIL illegal_frozen: pc=%h retired=%0d expected %h/%0d", pc, retired, exp_pc, exp_retired); end
        do_reset();
        n_checks++; if (trap !== 1'b0 || trap_cause !== 2'b00) begin n_fail++; $display("FAIL illegal_reset_clears: trap=%b cause=%b expected 0/00", trap, trap_cause); end
    endtask

    task automatic test_timeout();
        int req_cycles = 0, bad = 0;
        ack_enable = 1'b0; run = 1'b1;
        @(negedge clk);
        while (imem_bus.imem_req === 1'b1 && req_cycles < 20) begin req_cycles++; @(negedge clk); end
        n_checks++; if (req_cycles != TIMEOUT) begin n_fail++; $display("FAIL timeout_req_cycles: got %0d expected %0d", req_cycles, TIMEOUT); end
        n_checks++; if (trap !== 1'b1 || trap_cause !== 2'b10) begin n_fail++; $display("FAIL timeout_trap: trap=%b cause=%b expected 1/10", trap, trap_cause); end
        late_ack = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (ir !== NOP_INSTR || pc !== exp_pc || trap !== 1'b1 || trap_cause !== 2'b10 || imem_bus.imem_req !== 1'b0) bad++;
        end
        late_ack = 1'b0;
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL timeout_late_ack: state disturbed %0d cycles expected 0", bad); end
        do_reset();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_addi_zero_wait();
        test_delayed_ack();
        test_rd_zero();
        test_back_to_back();
        test_drop_run();
        test_async_reset();
        test_illegal();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
